// File: rtl/mem_pkg.sv
// Shared types and constants for the M-stage data memory.
package mem_pkg;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_BUSY = 2'd1,
      MS_DONE = 2'd2
   } mem_state_t;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned WORD_W     = 8 * WORD_BYTES;

   // Access attributes captured when a request is accepted in IDLE
   typedef struct packed {
      logic                  rd;
      logic                  wr;
      logic [WORD_BYTES-1:0] be;
      logic [WORD_W-1:0]     wdata;
   } mem_req_t;

   function automatic int unsigned idx_width(input int unsigned depth_words);
      return (depth_words > 1) ? $clog2(depth_words) : 1;
   endfunction

endpackage

// File: rtl/data_mem_stage_if.sv
// M-stage to data-memory bus: request, address, store data, load data and stall.
interface data_mem_stage_if;
   import mem_pkg::*;

   logic                  MemReadM;
   logic                  MemWriteM;
   logic [WORD_BYTES-1:0] byteEnable;
   logic [WORD_W-1:0]     ALUResultM;
   logic [WORD_W-1:0]     WriteDataM;
   logic [WORD_W-1:0]     ReadDataM;
   logic                  StallM;

   modport master (
      output MemReadM, MemWriteM, byteEnable, ALUResultM, WriteDataM,
      input  ReadDataM, StallM
   );

   modport slave (
      input  MemReadM, MemWriteM, byteEnable, ALUResultM, WriteDataM,
      output ReadDataM, StallM
   );

endinterface

// File: rtl/data_mem_stage_be_ram.sv
// Single-port RAM with per-byte write enables and a registered, clearable read port.
module be_ram
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = idx_width(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic                  rd_clr,
   input  logic                  rd_en,
   input  logic [WORD_BYTES-1:0] wr_be,
   input  logic [IDX_W-1:0]      addr,
   input  logic [WORD_W-1:0]     wdata,
   output logic [WORD_W-1:0]     rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   // Byte-lane writes; array contents are deliberately not reset
   always_ff @(posedge clk) begin
      for (int b = 0; b < int'(WORD_BYTES); b++) begin
         if (wr_be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Read register only updates on a load, so it holds across stores and idle
   always_ff @(posedge clk) begin
      if (rd_clr) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_stage.sv
// Fixed-latency data memory for the M stage; stalls the pipeline while an access is in flight.
module data_mem_stage
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic            clk,
   input  logic            reset,
   data_mem_stage_if.slave bus
);

   localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] IDLE = MS_IDLE;
   localparam logic [1:0] BUSY = MS_BUSY;
   localparam logic [1:0] DONE = MS_DONE;

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   mem_req_t              cap_q;
   logic [IDX_W-1:0]      idx_q;
   logic [IDX_W-1:0]      idx_in;
   logic [IDX_W-1:0]      ram_addr;
   logic [WORD_BYTES-1:0] wr_be_c;
   logic [WORD_BYTES-1:0] ram_be;
   logic [WORD_W-1:0]     ram_rdata;
   logic                  req_c;
   logic                  cap_en_c;
   logic                  rd_en_c;
   logic                  stall_c;
   logic                  unused_addr_bits;

   assign req_c  = bus.MemReadM | bus.MemWriteM;
   assign idx_in = bus.ALUResultM[IDX_W+1:2];

   // Byte-offset and above-depth address bits select nothing; addresses wrap
   assign unused_addr_bits = ^{bus.ALUResultM[WORD_W-1:IDX_W+2], bus.ALUResultM[1:0]};

   // State register and capture of the accepted request
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cap_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (cap_en_c) begin
            cap_q.rd    <= bus.MemReadM;
            cap_q.wr    <= bus.MemWriteM;
            cap_q.be    <= bus.byteEnable;
            cap_q.wdata <= bus.WriteDataM;
            idx_q       <= idx_in;
         end
      end
   end

   // Next state, counter and memory controls
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cap_en_c = 1'b0;
      rd_en_c  = 1'b0;
      wr_be_c  = '0;
      stall_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_c) begin
               stall_c  = 1'b1;
               cap_en_c = 1'b1;
               cnt_d    = CNT_W'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d = DONE;
                  rd_en_c = bus.MemReadM;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            stall_c = 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               rd_en_c = cap_q.rd;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            // A request still held here belongs to the instruction just served
            state_d = IDLE;
            if (cap_q.wr) begin
               wr_be_c = cap_q.be;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // In IDLE only a LATENCY=1 load reads, and it must use the live address
   assign ram_addr = (state_q == IDLE) ? idx_in : idx_q;
   assign ram_be   = reset ? '0 : wr_be_c;

   be_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk    (clk),
      .rd_clr (reset),
      .rd_en  (rd_en_c),
      .wr_be  (ram_be),
      .addr   (ram_addr),
      .wdata  (cap_q.wdata),
      .rdata  (ram_rdata)
   );

   assign bus.ReadDataM = ram_rdata;
   assign bus.StallM    = stall_c;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed self-checking bench for data_mem_stage (DEPTH_WORDS=1024, LATENCY=2).
module tb_data_mem_stage;

   logic clk;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   data_mem_stage_if bus ();

   data_mem_stage #(
      .DEPTH_WORDS (1024),
      .LATENCY     (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Issue one access at a negedge and hold it until StallM drops (the DONE cycle)
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be,
                            output logic [31:0] rdata, output int stalls,
                            output int start_cyc, output int done_cyc);
      int guard;
      @(negedge clk);
      bus.MemReadM   = rd;
      bus.MemWriteM  = wr;
      bus.ALUResultM = addr;
      bus.WriteDataM = wd;
      bus.byteEnable = be;
      start_cyc = cyc;
      #1;
      stalls = 0;
      guard  = 0;
      while (bus.StallM === 1'b1 && guard < 20) begin
         stalls++;
         guard++;
         @(negedge clk);
         #1;
      end
      tests++;
      if (guard >= 20) begin
         fails++;
         $display("FAIL access_timeout addr=%h: StallM still high after %0d cycles", addr, guard);
      end
      rdata    = bus.ReadDataM;
      done_cyc = cyc;
      bus.MemReadM  = 1'b0;
      bus.MemWriteM = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.MemReadM   = 1'b0;
      bus.MemWriteM  = 1'b0;
      bus.byteEnable = 4'h0;
      bus.ALUResultM = 32'h0;
      bus.WriteDataM = 32'h0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         tests++;
         if (bus.StallM !== 1'b0) begin
            fails++;
            $display("FAIL reset_stall cycle %0d: got %b want 0", i, bus.StallM);
         end
         tests++;
         if (bus.ReadDataM !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdata cycle %0d: got %h want 00000000", i, bus.ReadDataM);
         end
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd;
      int st, s0, d0, s1, d1;
      do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, st, s0, d0);
      tests++;
      if (st != 2) begin fails++; $display("FAIL store_stalls: got %0d want 2", st); end
      tests++;
      if (rd !== 32'h0) begin fails++; $display("FAIL store_holds_rdata: got %h want 00000000", rd); end
      idle(1);
      do_access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, st, s1, d1);
      tests++;
      if (st != 2) begin fails++; $display("FAIL load_stalls: got %0d want 2", st); end
      tests++;
      if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL load_data: got %h want deadbeef", rd); end
      tests++;
      if (d1 - s0 != 6) begin fails++; $display("FAIL load_done_offset: got %0d want 6", d1 - s0); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd;
      int st, s, d;
      do_access(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, st, s, d);
      do_access(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, st, s, d);
      do_access(1'b1, 1'b0, 32'h23, 32'h0, 4'h0, rd, st, s, d);
      tests++;
      if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL byte_lanes: got %h want 11bb33dd", rd); end
   endtask

   task automatic test_wrap();
      logic [31:0] rd;
      int st, s, d;
      do_access(1'b0, 1'b1, 32'h1004, 32'h5, 4'hF, rd, st, s, d);
      do_access(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rd, st, s, d);
      tests++;
      if (rd !== 32'h5) begin fails++; $display("FAIL wrap: got %h want 00000005", rd); end
   endtask

   task automatic test_back_to_back_rw();
      logic [31:0] rd;
      int st, s0, d0, s1, d1;
      do_access(1'b0, 1'b1, 32'h30, 32'h1, 4'hF, rd, st, s0, d0);
      do_access(1'b1, 1'b1, 32'h30, 32'h2, 4'hF, rd, st, s1, d1);
      tests++;
      if (rd !== 32'h1) begin fails++; $display("FAIL rw_old_data: got %h want 00000001", rd); end
      tests++;
      if (s1 - s0 != 3) begin fails++; $display("FAIL back_to_back_cost: got %0d want 3", s1 - s0); end
      do_access(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, rd, st, s0, d0);
      tests++;
      if (rd !== 32'h2) begin fails++; $display("FAIL rw_new_data: got %h want 00000002", rd); end
   endtask

   task automatic test_be_zero();
      logic [31:0] rd;
      int st, s, d;
      do_access(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 4'h0, rd, st, s, d);
      tests++;
      if (st != 2) begin fails++; $display("FAIL be0_stalls: got %0d want 2", st); end
      tests++;
      if (rd !== 32'h2) begin fails++; $display("FAIL be0_holds_rdata: got %h want 00000002", rd); end
      do_access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, st, s, d);
      tests++;
      if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL be0_no_change: got %h want deadbeef", rd); end
   endtask

   task automatic test_reset_busy();
      logic [31:0] rd;
      int st, s, d;
      do_access(1'b0, 1'b1, 32'h100, 32'h0, 4'hF, rd, st, s, d);
      do_access(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, rd, st, s, d);
      tests++;
      if (rd !== 32'h2) begin fails++; $display("FAIL pre_abort_rdata: got %h want 00000002", rd); end
      @(negedge clk);
      bus.MemWriteM  = 1'b1;
      bus.ALUResultM = 32'h100;
      bus.WriteDataM = 32'hFFFFFFFF;
      bus.byteEnable = 4'hF;
      #1;
      tests++;
      if (bus.StallM !== 1'b1) begin fails++; $display("FAIL abort_idle_stall: got %b want 1", bus.StallM); end
      @(negedge clk);
      #1;
      tests++;
      if (bus.StallM !== 1'b1) begin fails++; $display("FAIL abort_busy_stall: got %b want 1", bus.StallM); end
      reset = 1'b1;
      bus.MemWriteM = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests++;
      if (bus.StallM !== 1'b0) begin fails++; $display("FAIL abort_stall: got %b want 0", bus.StallM); end
      tests++;
      if (bus.ReadDataM !== 32'h0) begin fails++; $display("FAIL abort_rdata: got %h want 00000000", bus.ReadDataM); end
      idle(1);
      do_access(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, rd, st, s, d);
      tests++;
      if (rd !== 32'h0) begin fails++; $display("FAIL abort_no_write: got %h want 00000000", rd); end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_byte_lanes();
      test_wrap();
      test_back_to_back_rw();
      test_be_zero();
      test_reset_busy();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_mem_stage.md
# data_mem_stage

Memory-stage data memory with a fixed multi-cycle access latency, sitting directly downstream of the pipelined datapath's M-stage register. It consumes the M-stage address (ALUResultM), store data (WriteDataM), byte enables and read/write strobes, and returns ReadDataM to the write-back register. While an access is in flight it raises StallM so the hazard unit freezes the pipeline.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- LATENCY, 2: stall cycles per access; must be ≥ 1.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- MemReadM  in  1  load request in M stage.
- MemWriteM  in  1  store request in M stage.
- byteEnable  in  4  store lane mask; bit i covers bits 8i+7:8i.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data, registered.
- StallM  out  1  pipeline hold request to the hazard unit.

## Operation
- Word index = ALUResultM[log2(DEPTH_WORDS)+1:2].
  - Bits [1:0] are ignored.
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS×4.
- Request = MemReadM | MemWriteM.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - With request: capture index, WriteDataM, byteEnable, MemWriteM and MemReadM; load count = LATENCY−1.
    - If LATENCY = 1, go to DONE; otherwise go to BUSY.
    - Without request: stay in IDLE.
  - BUSY:
    - If count = 1, go to DONE; otherwise decrement count.
    - On leaving BUSY: ReadDataM ← mem[captured index], for reads only.
    - For LATENCY = 1, that load happens on the IDLE→DONE edge.
  - DONE:
    - On the clock edge leaving DONE, write captured bytes under captured byteEnable when captured write = 1.
    - Always go to IDLE; a request still asserted in DONE is the same instruction and is ignored.
- StallM = (IDLE & request) | BUSY; 0 in DONE.
- The pipeline holds M-stage inputs stable while StallM = 1. Values captured in IDLE are used, so later input changes are don't-care.
- Read and write both asserted: read returns pre-write contents and write is performed.
- byteEnable = 0 with MemWriteM: full access timing, no memory change.
- ReadDataM holds its last loaded value through write-only accesses and idle cycles.
- Reset:
  - state = IDLE, StallM = 0, ReadDataM = 0.
  - Memory contents are not reset.
  - Reset during BUSY or DONE aborts the access: no write occurs, and ReadDataM is forced to 0.

## Timing
- Request first seen in IDLE at cycle t:
  - StallM is high for cycles t … t+LATENCY−1.
  - At cycle t+LATENCY: state = DONE, StallM = 0, ReadDataM valid, and the pipeline advances at the end of that cycle.
- The store takes effect at the edge ending cycle t+LATENCY. A load issued in IDLE at t+LATENCY+1 observes it.
- Back-to-back accesses cost LATENCY+1 cycles each (LATENCY stalls + 1 DONE).
- StallM is combinational from request in IDLE: same-cycle assertion, no register delay.

## Structure
- Shared package `mem_pkg`:
  - state enum `mem_state_t` (IDLE, BUSY, DONE);
  - constant `WORD_BYTES = 4`;
  - address-index width function.
- Sub-module `be_ram`: synchronous single-port RAM with 4 byte-lane write enables and synchronous read.
  - `data_mem_stage` holds the FSM, counter, capture registers and ReadDataM.

## Test plan
- Reset, then idle 5 cycles → StallM = 0 and ReadDataM = 0x00000000 throughout.
- LATENCY = 2: store 0xDEADBEEF to 0x10 with byteEnable = 4'b1111, then load 0x10 →
  - StallM high 2 cycles for each access;
  - ReadDataM = 0xDEADBEEF in the load's DONE cycle, which is 6 cycles after the store request.
- Byte lanes: after the word at 0x20 holds 0x11223344, store 0xAABBCCDD with byteEnable = 4'b0101, then load 0x23 → 0x11BB33DD (bits [1:0] ignored).
- Wrap: DEPTH_WORDS = 1024, store 0x5 to 0x1004, then load 0x4 → 0x00000005.
- Simultaneous read+write: word 0x30 holds 0x1, then read+write 0x30 with 0x2 → ReadDataM = 0x1; a following load returns 0x2.
- Reset asserted during BUSY of a store of 0xFFFFFFFF to word 0x40 (previous value 0x0) → next cycle IDLE, StallM = 0; a later load returns 0x0.
